uart_echo_tx: RTL

//  Serial transmitter for the APU register link, running opposite to the UART receive path.

---
 rtl/uart_echo_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_echo_tx.sv
// uart_echo_tx
//   Echoes every completed APU register write back to the host as a two-byte
//   8N1 record on the serial line. The first byte is {4'b1000, addr} and the
//   second byte is the data. Writes wait in a small FIFO. A write that arrives
//   while the FIFO is full, with no pop in the same cycle, is dropped. A drop
//   sets the sticky overflow flag.
//
// Ports
//   apu_clk   in   1  APU clock, rising edge
//   rst_n     in   1  synchronous, active-low reset
//   wr_valid  in   1  one-cycle pulse: a register write completed
//   wr_addr   in   4  register index of that write
//   wr_data   in   8  value written
//   tx        out  1  serial output, idle high
//   busy      out  1  FIFO non-empty or a record in flight
//   overflow  out  1  sticky: a write was dropped on a full FIFO
module uart_echo_tx #(
  parameter int CLKRATE    = 1_790_000,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV   = CLKRATE / BAUDRATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic             second_q;    // set while byte1 (the data byte) is on the line
  logic             tx_q;
  logic             busy_q;
  logic             overflow_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W-1:0] wptr_d, rptr_d;
  logic             overflow_d;

  logic [11:0]      mem_q [FIFO_DEPTH];
  logic [7:0]       shreg_q;
  logic [7:0]       byte1_q;
  logic [11:0]      rd_rec;

  logic empty, full, pop, push, bit_end;

  assign rd_rec  = mem_q[rptr_q[AW-1:0]];
  assign bit_end = (baud_q == BAUD_LAST);

  // FIFO control. The extra pointer MSB tells full apart from empty.
  always_comb begin
    empty      = (wptr_q == rptr_q);
    full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop        = (state_q == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    push       = wr_valid && (!full || pop);
    wptr_d     = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    overflow_d = overflow_q | (wr_valid & full & ~pop);
  end

  // Control state and registered outputs. tx is a registered copy of the
  // current state, so the line lags the FSM by exactly one cycle.
  always_ff @(posedge apu_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      second_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_q != S_IDLE) || !empty;

      if (state_q == S_IDLE) baud_q <= '0;
      else                   baud_q <= bit_end ? '0 : baud_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          bit_q <= '0;
          if (pop) begin
            second_q <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          tx_q <= shreg_q[0];
          if (bit_end) begin
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (!second_q) begin
              // Data byte follows the address byte without a gap.
              second_q <= 1'b1;
              state_q  <= S_START;
            end else begin
              second_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: FIFO storage and the byte shift register (no reset needed).
  always_ff @(posedge apu_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {wr_addr, wr_data};
    if (pop) begin
      shreg_q <= {4'b1000, rd_rec[11:8]};
      byte1_q <= rd_rec[7:0];
    end else if (state_q == S_DATA && bit_end) begin
      shreg_q <= shreg_q >> 1;
    end else if (state_q == S_STOP && bit_end && !second_q) begin
      shreg_q <= byte1_q;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule
